// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU and its multi-cycle sequencer.
package alu_pkg;

    localparam logic [4:0] ALU_ZERO  = 5'b00000;
    localparam logic [4:0] ALU_PASSX = 5'b00001;
    localparam logic [4:0] ALU_ADD   = 5'b01000;
    localparam logic [4:0] ALU_ADC   = 5'b01010;
    localparam logic [4:0] ALU_SUB   = 5'b01011;
    localparam logic [4:0] ALU_SBB   = 5'b01101;
    localparam logic [4:0] ALU_SRC   = 5'b11001;

    localparam logic [1:0] CMD_ADD16 = 2'b00;
    localparam logic [1:0] CMD_SUB16 = 2'b01;
    localparam logic [1:0] CMD_MUL8  = 2'b10;

    localparam int FLAG_S  = 2;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_CY = 0;

    // Z is taken over the full 16-bit word, never from the per-byte ALU flag.
    function automatic logic [2:0] mk_flags(input logic [15:0] r, input logic cy);
        logic [2:0] f;
        f          = '0;
        f[FLAG_S]  = r[15];
        f[FLAG_Z]  = (r == 16'h0000);
        f[FLAG_CY] = cy;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq.sv
// Sequences the shared 8-bit ALU through 16-bit ADD/SUB and 8x8 shift-add MUL,
// owning the ALU inputs only while the arbiter grants the bus.
module alu_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  cmd,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [2:0]  flags,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_t,
    output logic        alu_cy,
    output logic [4:0]  alu_op,
    input  logic [2:0]  alu_flag,
    input  logic [7:0]  alu_result
);

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_MADD, S_MSHR, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [7:0]  r_hi_q, r_hi_d, r_lo_q, r_lo_d;
    logic        c_q, c_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic [2:0]  flags_q, flags_d;
    logic [15:0] mul_word;
    logic        alu_sz_unused;

    assign alu_sz_unused = ^alu_flag[FLAG_S:FLAG_Z];
    assign result        = result_q;
    assign flags         = flags_q;
    assign mul_word      = {alu_result, r_hi_q[0], r_lo_q[7:1]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cmd_d    = cmd_q;
        r_hi_d   = r_hi_q;
        r_lo_d   = r_lo_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        alu_req  = 1'b0;
        alu_x    = 8'h00;
        alu_t    = 8'h00;
        alu_cy   = 1'b0;
        alu_op   = ALU_ZERO;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    cmd_d  = cmd;
                    r_hi_d = 8'h00;
                    r_lo_d = 8'h00;
                    c_d    = 1'b0;
                    cnt_d  = 3'd0;
                    case (cmd)
                        CMD_ADD16, CMD_SUB16: state_d = S_LO;
                        CMD_MUL8: begin
                            r_lo_d  = b[7:0];
                            state_d = S_MADD;
                        end
                        default: begin
                            result_d = 16'h0000;
                            flags_d  = mk_flags(16'h0000, 1'b0);
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end
            S_LO: begin
                alu_req = 1'b1;
                alu_x   = a_q[7:0];
                alu_t   = b_q[7:0];
                alu_op  = (cmd_q == CMD_SUB16) ? ALU_SUB : ALU_ADD;
                if (alu_gnt) begin
                    r_lo_d  = alu_result;
                    c_d     = alu_flag[FLAG_CY];
                    state_d = S_HI;
                end
            end
            S_HI: begin
                alu_req = 1'b1;
                alu_x   = a_q[15:8];
                alu_t   = b_q[15:8];
                // The ALU reads Cy as borrow on SBB, while c_q holds "no borrow".
                alu_op  = (cmd_q == CMD_SUB16) ? ALU_SBB : ALU_ADC;
                alu_cy  = (cmd_q == CMD_SUB16) ? ~c_q : c_q;
                if (alu_gnt) begin
                    r_hi_d   = alu_result;
                    result_d = {alu_result, r_lo_q};
                    flags_d  = mk_flags({alu_result, r_lo_q},
                                        (cmd_q == CMD_SUB16) ? ~alu_flag[FLAG_CY] : alu_flag[FLAG_CY]);
                    state_d  = S_DONE;
                end
            end
            S_MADD: begin
                alu_req = 1'b1;
                alu_x   = r_hi_q;
                alu_op  = r_lo_q[0] ? ALU_ADD : ALU_PASSX;
                alu_t   = r_lo_q[0] ? a_q[7:0] : 8'h00;
                if (alu_gnt) begin
                    r_hi_d  = alu_result;
                    c_d     = alu_flag[FLAG_CY];
                    state_d = S_MSHR;
                end
            end
            S_MSHR: begin
                alu_req = 1'b1;
                alu_x   = r_hi_q;
                alu_cy  = c_q;
                alu_op  = ALU_SRC;
                if (alu_gnt) begin
                    r_hi_d = alu_result;
                    r_lo_d = {r_hi_q[0], r_lo_q[7:1]};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        result_d = mul_word;
                        flags_d  = mk_flags(mul_word, alu_result != 8'h00);
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_MADD;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cmd_q    <= '0;
            r_hi_q   <= '0;
            r_lo_q   <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cmd_q    <= cmd_d;
            r_hi_q   <= r_hi_d;
            r_lo_q   <= r_lo_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural 8-bit ALU beside the DUT, plain-arithmetic reference results.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk, rst, start, busy, done, alu_req, alu_gnt, alu_cy;
    logic [1:0]  cmd;
    logic [15:0] a, b, result;
    logic [2:0]  flags, alu_flag;
    logic [7:0]  alu_x, alu_t, alu_result;
    logic [4:0]  alu_op;

    int checks = 0;
    int errors = 0;

    alu_seq dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .flags(flags),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_x(alu_x), .alu_t(alu_t),
        .alu_cy(alu_cy), .alu_op(alu_op), .alu_flag(alu_flag), .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: subtract ops report Cy=1 for "no borrow" and consume Cy as borrow.
    always_comb begin
        logic [8:0] w;
        w = 9'h000;
        case (alu_op)
            ALU_PASSX: w = {1'b0, alu_x};
            ALU_ADD:   w = {1'b0, alu_x} + {1'b0, alu_t};
            ALU_ADC:   w = {1'b0, alu_x} + {1'b0, alu_t} + {8'h00, alu_cy};
            ALU_SUB:   begin w = {1'b0, alu_x} - {1'b0, alu_t};                  w[8] = ~w[8]; end
            ALU_SBB:   begin w = {1'b0, alu_x} - {1'b0, alu_t} - {8'h00, alu_cy}; w[8] = ~w[8]; end
            ALU_SRC:   w = {alu_x[0], alu_cy, alu_x[7:1]};
            default:   w = 9'h000;
        endcase
        alu_result = w[7:0];
        alu_flag   = {w[7], w[7:0] == 8'h00, w[8]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int base_lat(input logic [1:0] c);
        return (c == CMD_MUL8) ? 17 : ((c == 2'b11) ? 1 : 3);
    endfunction

    // Issues one command at the next edge and follows it to done.
    task automatic run(input logic [1:0] c, input logic [15:0] av, input logic [15:0] bv,
                       input int s_at, input int s_len, input bit poke, input string tag);
        logic [15:0] er;
        logic [2:0]  ef;
        logic        ecy, ec0;
        logic [22:0] snap;
        int          n, exp_lat;
        ecy = 1'b0;
        ec0 = 1'b0;
        snap = '0;
        case (c)
            CMD_ADD16: begin
                er  = av + bv;
                ecy = (int'(av) + int'(bv)) > 65535;
                ec0 = (int'(av[7:0]) + int'(bv[7:0])) > 255;
            end
            CMD_SUB16: begin
                er  = av - bv;
                ecy = av < bv;
                ec0 = av[7:0] < bv[7:0];
            end
            CMD_MUL8: begin
                er  = 16'(av[7:0]) * 16'(bv[7:0]);
                ecy = er[15:8] != 8'h00;
            end
            default: er = 16'h0000;
        endcase
        ef = {er[15], er == 16'h0000, ecy};
        exp_lat = base_lat(c) + s_len;
        alu_gnt = 1'b1;
        start = 1'b1; cmd = c; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); cmd = 2'($urandom);
        n = 1;
        while (!done && n < 64) begin
            if (alu_op == ALU_ADC || alu_op == ALU_SBB)
                chk({tag, "_hi_cy"}, 32'(alu_cy), 32'(ec0));
            if (n == s_at) snap = {alu_req, alu_op, alu_x, alu_t, alu_cy};
            if (s_len > 0 && n > s_at && n <= s_at + s_len)
                chk({tag, "_stall_hold"}, 32'({alu_req, alu_op, alu_x, alu_t, alu_cy}), 32'(snap));
            alu_gnt = (n >= s_at && n < s_at + s_len) ? 1'b0 : 1'b1;
            start = poke && (n == 2);
            if (start) begin cmd = CMD_ADD16; a = 16'hAAAA; b = 16'h5555; end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        alu_gnt = 1'b1;
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_result"}, 32'(result), 32'(er));
        chk({tag, "_flags"}, 32'(flags), 32'(ef));
        chk({tag, "_done_req_busy"}, 32'({alu_req, busy, alu_op}), 32'({1'b0, 1'b1, ALU_ZERO}));
        @(posedge clk); #1;
        chk({tag, "_after_done"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        logic [1:0] rc;
        int         sl, sa;
        bit         seen_done;
        rst = 1'b1; start = 1'b0; cmd = 2'b00; a = 16'h0; b = 16'h0; alu_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_res_flags", 32'({result, flags}), 32'd0);
        chk("reset_ctrl", 32'({busy, done, alu_req, alu_x, alu_t, alu_cy, alu_op}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(CMD_ADD16, 16'h12FF, 16'h0001, 0, 0, 1'b0, "add_carry_lo");
        run(CMD_ADD16, 16'hFFFF, 16'h0001, 0, 0, 1'b0, "add_wrap");
        run(CMD_SUB16, 16'h1000, 16'h0001, 0, 0, 1'b0, "sub_borrow_lo");
        run(CMD_SUB16, 16'h0000, 16'h0001, 0, 0, 1'b0, "sub_wrap");
        run(CMD_MUL8,  16'h00FF, 16'h00FF, 0, 0, 1'b0, "mul_ff");
        run(CMD_MUL8,  16'h0000, 16'h0037, 0, 0, 1'b0, "mul_zero");
        run(2'b11,     16'h1234, 16'h5678, 0, 0, 1'b0, "reserved");
        run(CMD_MUL8,  16'h000D, 16'h000B, 6, 5, 1'b1, "mul_stall");

        // Reset during cycle 8 of a multiply must abort with no done pulse.
        start = 1'b1; cmd = CMD_MUL8; a = 16'h00C3; b = 16'h0077; alu_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_res_flags", 32'({result, flags}), 32'd0);
        chk("midrst_ctrl", 32'({busy, done, alu_req, alu_x, alu_t, alu_cy, alu_op}), 32'd0);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        chk("midrst_quiet", 32'(seen_done), 32'd0);
        run(CMD_ADD16, 16'h0F0F, 16'h10F1, 0, 0, 1'b0, "post_rst_add");

        for (int i = 0; i < 24; i++) begin
            rc = 2'($urandom_range(0, 3));
            if (rc == 2'b11) begin
                sl = 0; sa = 0;
            end else begin
                sl = $urandom_range(0, 3);
                sa = $urandom_range(1, base_lat(rc) - 1);
            end
            run(rc, 16'($urandom), 16'($urandom), sa, sl, 1'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
